mips_fetch: RTL and testbench

MIPS_FETCH -- requirements
Module: mips_fetch

---
 rtl/mips_fetch.sv | 180 ++++++++++++++++++
 tb/tb_mips_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
// mips_fetch: MIPS instruction fetch unit. Issues credit-limited word fetches,
// buffers up to two returned instructions in order and flushes stale responses
// after a redirect.
module mips_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic [31:0] inst_pc
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  occ_q, occ_d;
   logic [1:0]  outst_q, outst_d;
   logic [1:0]  drop_q, drop_d;
   logic [31:0] word0_q, word0_d, word1_q, word1_d;
   logic [31:0] wpc0_q, wpc0_d, wpc1_q, wpc1_d;

   logic        credit;
   logic        resp_ok;
   logic        push;
   logic        pop;
   logic [31:0] resp_pc;
   logic [1:0]  outst_after_resp;

   // Request issue, response acceptance and buffer handshake decode
   always_comb begin
      credit     = ({1'b0, occ_q} + {1'b0, outst_q}) < 3'd2;
      imem_req   = (state_q == StRun) && !halt && !redirect && credit;
      imem_addr  = pc_q;
      // A response with nothing outstanding (e.g. one issued before reset) is stray
      resp_ok    = imem_rvalid && (outst_q != 2'd0) && (state_q != StIdle);
      push       = resp_ok && (state_q == StRun);
      inst_valid = (occ_q != 2'd0);
      pop        = inst_valid && inst_ready;
      // Responses are in order and the PC advanced once per request, so the
      // oldest outstanding request sits outst_q words behind the PC.
      resp_pc    = pc_q - {28'd0, outst_q, 2'b00};
      outst_after_resp = outst_q - {1'b0, resp_ok};
   end

   // Next-state: PC, credit counters, instruction buffer and fetch FSM
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      occ_d   = occ_q;
      outst_d = outst_after_resp + {1'b0, imem_req};
      drop_d  = drop_q;
      word0_d = word0_q;
      word1_d = word1_q;
      wpc0_d  = wpc0_q;
      wpc1_d  = wpc1_q;

      if (imem_req) begin
         pc_d = pc_q + 32'd4;
      end

      unique case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               word0_d = imem_rdata;
               wpc0_d  = resp_pc;
            end else begin
               word1_d = imem_rdata;
               wpc1_d  = resp_pc;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            word0_d = word1_q;
            wpc0_d  = wpc1_q;
            occ_d   = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               word0_d = imem_rdata;
               wpc0_d  = resp_pc;
            end else begin
               word0_d = word1_q;
               wpc0_d  = wpc1_q;
               word1_d = imem_rdata;
               wpc1_d  = resp_pc;
            end
         end
         default: ;
      endcase

      unique case (state_q)
         StIdle:  state_d = StRun;
         StRun:   ;
         StFlush: begin
            if (resp_ok) begin
               drop_d = drop_q - 2'd1;
               if (drop_q == 2'd1) begin
                  state_d = StRun;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Redirect overrides everything: same-cycle push/pop are discarded and
      // every request still in flight becomes a response to drop.
      if (redirect) begin
         pc_d    = redirect_pc & 32'hFFFF_FFFC;
         occ_d   = 2'd0;
         outst_d = outst_after_resp;
         drop_d  = outst_after_resp;
         state_d = (outst_after_resp != 2'd0) ? StFlush : StRun;
      end
   end

   // Head-entry field slices, forced to zero while the buffer is empty
   always_comb begin
      opcode  = '0;
      funct   = '0;
      rs      = '0;
      rt      = '0;
      rd      = '0;
      imm     = '0;
      inst_pc = '0;
      if (inst_valid) begin
         opcode  = word0_q[31:26];
         rs      = word0_q[25:21];
         rt      = word0_q[20:16];
         rd      = word0_q[15:11];
         funct   = word0_q[5:0];
         imm     = word0_q[15:0];
         inst_pc = wpc0_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         occ_q   <= 2'd0;
         outst_q <= 2'd0;
         drop_q  <= 2'd0;
         word0_q <= '0;
         word1_q <= '0;
         wpc0_q  <= '0;
         wpc1_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         occ_q   <= occ_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         word0_q <= word0_d;
         word1_q <= word1_d;
         wpc0_q  <= wpc0_d;
         wpc1_q  <= wpc1_d;
      end
   end

endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed bench for mips_fetch with an in-order memory model
// and a scoreboard of expected instructions.
module tb_mips_fetch;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        halt;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] inst_pc;

   always #5 clock = ~clock;

   mips_fetch #(.RESET_PC(RESET_PC)) dut (
      .clock       (clock),
      .reset       (reset),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .opcode      (opcode),
      .funct       (funct),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .imm         (imm),
      .inst_pc     (inst_pc)
   );

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   typedef struct packed {
      int          due;
      logic [31:0] addr;
   } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   exp_t        mon_e;
   pend_t       mem_p;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          req_count = 0;
   int          pop_count = 0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_pc = RESET_PC;

   // Memory contents: address 0x00400000 holds add $8,$9,$10 (0x012A4020)
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h012A_4020 ^ {addr[15:0], 16'h0000};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
      #1;
   endtask

   // Memory: one in-order response per cycle, lat cycles after the request cycle
   always @(posedge clock) begin
      #1;
      cyc = cyc + 1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         mem_p       = pend_q.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mem_p.addr);
      end
   end

   // Monitor: request legality, scoreboard push on request, compare on pop
   always @(negedge clock) begin
      if (mon_en) begin
         if (!reset) begin
            exp_q.delete();
            exp_pc = RESET_PC;
         end else begin
            if (!inst_valid) begin
               check("empty_fields_zero", 64'({opcode, funct, rs, rt, rd, imm}), 64'd0);
            end
            if (halt || redirect) begin
               check("no_req_halt_redirect", 64'(imem_req), 64'd0);
            end
            if (imem_req) begin
               check("credit", 64'(exp_q.size() < 2), 64'd1);
               check("req_addr", 64'(imem_addr), 64'(exp_pc));
            end
            if (redirect) begin
               exp_q.delete();
               exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
               if (inst_valid && inst_ready) begin
                  check("pop_expected", 64'(exp_q.size() > 0), 64'd1);
                  if (exp_q.size() > 0) begin
                     mon_e = exp_q.pop_front();
                     check("head_fields", 64'({opcode, rs, rt, imm}), 64'(mon_e.word));
                     check("head_rd_funct", 64'({rd, funct}),
                           64'({mon_e.word[15:11], mon_e.word[5:0]}));
                     check("head_pc", 64'(inst_pc), 64'(mon_e.pc));
                  end
                  pop_count++;
               end
               if (imem_req) begin
                  exp_q.push_back('{word: mem_word(imem_addr), pc: imem_addr});
                  pend_q.push_back('{due: cyc + lat, addr: imem_addr});
                  req_count++;
                  exp_pc = exp_pc + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   int          r0;
   int          n;
   logic [31:0] next_pc;

   initial begin
      reset       = 1'b0;
      halt        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      mon_en = 1'b1;
      sample();
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(inst_valid), 64'd0);
      check("rst_fields", 64'({opcode, funct, rs, rt, rd, imm}), 64'd0);

      // Basic stream, 1-cycle memory
      tick();
      reset = 1'b1;
      sample();
      check("idle_no_req", 64'(imem_req), 64'd0);
      tick();
      sample();
      check("first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0040_0000}));
      tick();
      sample();
      check("valid_not_yet", 64'(inst_valid), 64'd0);
      check("second_req", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0040_0004}));
      tick();
      sample();
      check("first_valid", 64'(inst_valid), 64'd1);
      check("decode_add", 64'({opcode, funct, rs, rt, rd}),
            64'({6'd0, 6'h20, 5'd9, 5'd10, 5'd8}));
      check("first_inst_pc", 64'(inst_pc), 64'h0040_0000);
      repeat (6) tick();

      // Decoder stall: exactly two requests fill the buffer
      halt = 1'b1;
      repeat (6) tick();
      sample();
      check("drained", 64'(inst_valid), 64'd0);
      tick();
      halt       = 1'b0;
      inst_ready = 1'b0;
      r0         = req_count;
      repeat (5) tick();
      sample();
      check("stall_two_reqs", 64'(req_count - r0), 64'd2);
      check("stall_full_no_req", 64'({inst_valid, imem_req}), 64'd2);
      tick();
      inst_ready = 1'b1;
      sample();
      check("pop_cycle_no_req", 64'(imem_req), 64'd0);
      tick();
      sample();
      check("req_after_pop", 64'(imem_req), 64'd1);
      repeat (8) tick();

      // Redirect with two requests in flight, 3-cycle memory
      halt = 1'b1;
      repeat (6) tick();
      lat  = 3;
      halt = 1'b0;
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0103;
      tick();
      redirect = 1'b0;
      n = 0;
      sample();
      while (!imem_req && n < 3) begin
         tick();
         sample();
         n++;
      end
      check("flush_resume_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0040_0100}));
      n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         sample();
         n++;
      end
      check("redir_first_valid", 64'(inst_valid), 64'd1);
      check("redir_first_pc", 64'(inst_pc), 64'h0040_0100);

      // Halt mid-stream
      tick();
      lat = 1;
      repeat (6) tick();
      n = 0;
      do begin
         tick();
         sample();
         n++;
      end while (!imem_req && n < 10);
      check("halt_setup_req", 64'(imem_req), 64'd1);
      tick();
      halt = 1'b1;
      r0   = pop_count;
      repeat (4) begin
         sample();
         check("halt_no_req", 64'(imem_req), 64'd0);
         tick();
      end
      check("halt_inflight_delivered", 64'(pop_count > r0), 64'd1);
      halt    = 1'b0;
      next_pc = exp_pc;
      sample();
      check("halt_resume", 64'({imem_req, imem_addr}), 64'({1'b1, next_pc}));
      repeat (6) tick();

      // Reset with one request in flight; its late response is stray
      halt = 1'b1;
      repeat (6) tick();
      lat  = 3;
      halt = 1'b0;
      sample();
      check("pre_reset_req", 64'(imem_req), 64'd1);
      tick();
      halt  = 1'b1;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      halt  = 1'b0;
      sample();
      check("post_reset_idle", 64'({imem_req, inst_valid}), 64'd0);
      tick();
      sample();
      check("post_reset_pc", 64'({imem_req, imem_addr}), 64'({1'b1, RESET_PC}));
      tick();
      sample();
      check("stray_ignored_a", 64'(inst_valid), 64'd0);
      tick();
      sample();
      check("stray_ignored_b", 64'(inst_valid), 64'd0);
      n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         sample();
         n++;
      end
      check("post_reset_first_pc", 64'({inst_valid, inst_pc}), 64'({1'b1, RESET_PC}));

      // PC wrap via redirect (low address bits ignored)
      tick();
      halt = 1'b1;
      lat  = 1;
      repeat (8) tick();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      halt     = 1'b0;
      sample();
      check("wrap_top", 64'({imem_req, imem_addr}), 64'({1'b1, 32'hFFFF_FFFC}));
      tick();
      sample();
      check("wrap_zero", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0000_0000}));

      // Drain and confirm every expected instruction was delivered
      tick();
      halt = 1'b1;
      repeat (10) tick();
      sample();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("final_empty", 64'(inst_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
